// File: rtl/regfile_sb.sv
// Integer register file with scoreboard: NRD async read ports, one sync writeback port, pending-write tracking.
// Optional macro REGFILE_BYPASS_EN adds same-cycle writeback-to-read forwarding on every read port.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  output logic [AW:0]         busy_cnt,
  output logic                any_busy
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;

  logic             w_wb_vld;
  logic             w_iss_vld;
  logic [NREGS-1:0] w_busy_clr;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_inc;
  logic             w_dec;
  logic [AW:0]      w_cnt_nxt;

  assign w_wb_vld  = wb_en && (wb_addr != '0);
  assign w_iss_vld = iss_en && (iss_addr != '0);

  // Writeback clear, then flush, then issue set; the count tracks the same net change.
  always_comb begin
    w_busy_clr = r_busy;
    if (w_wb_vld) w_busy_clr[wb_addr] = 1'b0;
    w_busy_nxt = flush ? '0 : w_busy_clr;
    if (w_iss_vld) w_busy_nxt[iss_addr] = 1'b1;

    w_dec = w_wb_vld && r_busy[wb_addr];
    w_inc = w_iss_vld && !w_busy_clr[iss_addr];

    w_cnt_nxt = r_busy_cnt;
    if (flush)
      w_cnt_nxt = w_iss_vld ? (AW+1)'(1) : '0;
    else if (w_inc && !w_dec)
      w_cnt_nxt = r_busy_cnt + (AW+1)'(1);
    else if (w_dec && !w_inc)
      w_cnt_nxt = r_busy_cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wb_vld) r_regs[wb_addr] <= wb_data;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;
  assign any_busy = (r_busy_cnt != '0);

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = rs_addr[g*AW +: AW];

    always_comb begin
      w_data = r_regs[w_addr];
      w_busy = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle issue to the written register makes it pending again.
      if (w_wb_vld && (w_addr == wb_addr)) begin
        w_data = wb_data;
        w_busy = w_iss_vld && (iss_addr == wb_addr);
      end
`else
`endif
      if (w_addr == '0) begin
        w_data = '0;
        w_busy = 1'b0;
      end
    end

    assign rs_data[g*XLEN +: XLEN] = w_data;
    assign rs_busy[g]              = w_busy;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file with an integrated scoreboard, for the pipelined successor of the single-cycle rv32 core.
- Provides NRD asynchronous read ports and one synchronous writeback port.
- The issue port marks destination registers as pending; the writeback port clears them.
- Per-port busy flags and an outstanding-writes counter are exported so decode can stall on RAW hazards.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers; power of two, >= 2; register 0 hardwired to zero
NRD, 2, number of read ports, >= 1
AW (localparam), $clog2(NREGS), register address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
rs_addr  input  NRD*AW  read addresses; port i = bits [i*AW +: AW]
rs_data  output  NRD*XLEN  read data; port i = bits [i*XLEN +: XLEN]
rs_busy  output  NRD  port i source has a pending write
iss_en  input  1  issue: mark iss_addr pending
iss_addr  input  AW  destination of issued instruction
wb_en  input  1  writeback strobe
wb_addr  input  AW  writeback destination
wb_data  input  XLEN  writeback data
flush  input  1  clear all pending marks (pipeline squash)
busy_cnt  output  AW+1  number of registers currently marked pending
any_busy  output  1  busy_cnt != 0

Behaviour:
- Reset (async, rst=1):
  - all registers = 0; busy[] = 0; busy_cnt = 0.
  - Outputs reset to: rs_data = 0 for every address, rs_busy = 0, any_busy = 0.
- Reads are combinational, zero latency:
  - address 0 returns 0 and busy 0 regardless of state.
  - otherwise returns regs[addr] and busy[addr].
- Writes are synchronous. On the rising edge with wb_en=1 and wb_addr != 0: regs[wb_addr] <= wb_data.
  - wb_en with wb_addr = 0 is ignored entirely (no data change, no busy change).
- Scoreboard update per rising edge, applied in this order, evaluated on the pre-edge state:
  1. Writeback clear: if wb_en and wb_addr != 0, clear busy[wb_addr].
  2. Flush: if flush, clear all busy bits.
  3. Issue set: if iss_en and iss_addr != 0, set busy[iss_addr].
- Consequences of that order:
  - issue and writeback to the same register in one cycle → busy stays 1 (the new producer wins), data is still written.
  - flush and issue in one cycle → only iss_addr is busy afterwards.
  - writeback to a non-busy register → data written, busy unchanged.
  - issue to an already-busy register → stays busy, count unchanged.
- busy_cnt:
  - registered; equals the popcount of busy[] after every edge.
  - maintained incrementally as +1 / -1 / 0 per edge; on flush it is set to 0 or 1.
  - never under- or overflows; maximum NREGS-1.
- any_busy is derived combinationally from busy_cnt.
- Reset asserted mid-operation clears everything immediately. The first edge after deassertion behaves as from the reset state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - write-to-read forwarding on every read port. When wb_en=1, wb_addr != 0 and rs_addr[i] == wb_addr in the same cycle: rs_data[i] = wb_data and rs_busy[i] = 0, unless iss_en=1 with iss_addr == wb_addr, in which case rs_busy[i] = 1.
  - forwarding is purely combinational; no added latency.
- Not defined:
  - rs_data[i] returns the pre-edge array value and rs_busy[i] the pre-edge busy bit.
  - the written value becomes visible the cycle after the writeback edge.

Test Plan:
- Reset then read all addresses on every port → rs_data = 0, rs_busy = 0, busy_cnt = 0, any_busy = 0.
- wb_en, addr 5, data 0xDEADBEEF; next cycle read 5 on port 0 and port 1 → both 0xDEADBEEF. wb_en to addr 0 with 0x1234 → read 0 returns 0.
- Issue 3, then issue 7, then writeback 3 with 0xA5A5A5A5 → busy_cnt 1, 2, 1; rs_busy for 3 = 0 and for 7 = 1; data at 3 = 0xA5A5A5A5.
- Same-cycle issue and writeback to 9 (data 0x11) → busy[9] = 1, busy_cnt +1 relative to before, data 0x11. Flush with issue 4 → busy_cnt = 1, only 4 busy.
- Writeback 12 with 0x55 while reading 12 in the same cycle:
  - with REGFILE_BYPASS_EN: rs_data = 0x55, rs_busy = 0 combinationally.
  - without: old value that cycle, 0x55 the next cycle.
- Assert rst mid-sequence with busy_cnt = 3 and registers non-zero → immediate zero on all outputs. After deassert, issue 2 → busy_cnt = 1.
